// File: rtl/noc_port_arbiter_if.sv
// noc_port_arbiter_if: requester-side and router-side signals of one shared NoC input port
interface noc_port_arbiter_if #(
  parameter int WIDTH   = 600,
  parameter int NUM_REQ = 4,
  parameter int CREDITS = 8,
  parameter int CNT_W   = 16
);
  localparam int ID_W = $clog2(NUM_REQ);
  localparam int CR_W = $clog2(CREDITS + 1);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_tail;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     out_valid;
  logic [WIDTH-1:0]         out_data;
  logic                     out_tail;
  logic [ID_W-1:0]          out_req_id;
  logic                     credit_in;
  logic [CR_W-1:0]          credit_count;
  logic                     credit_err;
  logic [NUM_REQ*CNT_W-1:0] grant_count;
  modport master (
    output req_valid, req_data, req_tail, credit_in,
    input  req_ready, out_valid, out_data, out_tail, out_req_id, credit_count, credit_err, grant_count
  );
  modport slave (
    input  req_valid, req_data, req_tail, credit_in,
    output req_ready, out_valid, out_data, out_tail, out_req_id, credit_count, credit_err, grant_count
  );
endinterface

// File: rtl/noc_port_arbiter.sv
// noc_port_arbiter: round-robin wormhole arbiter with credit flow control for one router input port
// Define NOC_ARB_STATS_EN to build the per-requester accepted-packet counters.
module noc_port_arbiter #(
  parameter int WIDTH   = 600,
  parameter int NUM_REQ = 4,
  parameter int CREDITS = 8,
  parameter int CNT_W   = 16
) (
  input logic clk,
  input logic rst,
  noc_port_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(NUM_REQ);
  localparam int CR_W = $clog2(CREDITS + 1);
  localparam logic [CR_W-1:0] CR_MAX = CR_W'(CREDITS);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t              state_q, state_d;
  logic [ID_W-1:0]     owner_q, owner_d, rr_q, rr_d, rr_id, win_id;
  logic [CR_W-1:0]     credit_q, credit_d;
  logic                credit_err_q, credit_err_d;
  logic                out_valid_q, out_valid_d, out_tail_q, out_tail_d;
  logic [WIDTH-1:0]    out_data_q, out_data_d;
  logic [ID_W-1:0]     out_id_q, out_id_d;
  logic [NUM_REQ-1:0]  hi_mask, hi_req, pick, pick_oh, ready;
  logic                has_cr, accept, acc_tail;
  // Masked/unmasked lowest-set-bit search keeps the round-robin pick flat (no serial wrap chain).
  always_comb begin
    hi_mask = ~((NUM_REQ'(1) << rr_q) - NUM_REQ'(1));
    hi_req = bus.req_valid & hi_mask;
    pick = |hi_req ? hi_req : bus.req_valid;
    pick_oh = pick & (~pick + NUM_REQ'(1));
    rr_id = '0;
    for (int i = 0; i < NUM_REQ; i++) rr_id = rr_id | (pick_oh[i] ? ID_W'(i) : '0);
    has_cr = credit_q != '0;
    win_id = state_q == LOCKED ? owner_q : rr_id;
    ready = !has_cr ? '0 : state_q == LOCKED ? NUM_REQ'(1) << owner_q : pick_oh;
    accept = |(bus.req_valid & ready);
    acc_tail = bus.req_tail[win_id];
    state_d = accept ? (acc_tail ? IDLE : LOCKED) : state_q;
    owner_d = accept ? win_id : owner_q;
    rr_d = accept && acc_tail ? (win_id == ID_W'(NUM_REQ - 1) ? '0 : win_id + 1'b1) : rr_q;
    credit_d = accept && !bus.credit_in ? credit_q - 1'b1 :
               !accept && bus.credit_in && credit_q != CR_MAX ? credit_q + 1'b1 : credit_q;
    credit_err_d = credit_err_q | (!accept && bus.credit_in && credit_q == CR_MAX);
    out_valid_d = accept;
    out_data_d = accept ? bus.req_data[win_id*WIDTH +: WIDTH] : out_data_q;
    out_tail_d = accept ? acc_tail : out_tail_q;
    out_id_d = accept ? win_id : out_id_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q <= '0;
      credit_q <= CR_MAX;
      credit_err_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_tail_q <= 1'b0;
      out_id_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q <= rr_d;
      credit_q <= credit_d;
      credit_err_q <= credit_err_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_tail_q <= out_tail_d;
      out_id_q <= out_id_d;
    end
  end
  assign bus.req_ready = ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data = out_data_q;
  assign bus.out_tail = out_tail_q;
  assign bus.out_req_id = out_id_q;
  assign bus.credit_count = credit_q;
  assign bus.credit_err = credit_err_q;
`ifdef NOC_ARB_STATS_EN
  logic [NUM_REQ*CNT_W-1:0] gc_q, gc_d;
  // One count per packet: only tail accepts bump the owner's counter.
  always_comb begin
    gc_d = gc_q;
    for (int r = 0; r < NUM_REQ; r++)
      if (accept && acc_tail && win_id == ID_W'(r)) gc_d[r*CNT_W +: CNT_W] = gc_q[r*CNT_W +: CNT_W] + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) gc_q <= '0;
    else gc_q <= gc_d;
  end
  assign bus.grant_count = gc_q;
`else
  assign bus.grant_count = '0;
`endif
endmodule

// File: tb/tb_noc_port_arbiter.sv
// tb_noc_port_arbiter: directed checks of arbitration, locking, credits, reset and stats
module tb_noc_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int fails = 0;
  noc_port_arbiter_if #(.WIDTH(16), .NUM_REQ(4), .CREDITS(4), .CNT_W(8)) b();
  noc_port_arbiter #(.WIDTH(16), .NUM_REQ(4), .CREDITS(4), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(b));
  always #5 clk = ~clk;

  function automatic logic [15:0] fd(input int r, input logic [7:0] s);
    return {8'(8'hA0 + r), s};
  endfunction

  task automatic drive(input logic [3:0] v, input logic [3:0] t, input logic [7:0] s, input logic cr);
    b.req_valid = v;
    b.req_tail = t;
    b.credit_in = cr;
    for (int r = 0; r < 4; r++) b.req_data[r*16 +: 16] = fd(r, s);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(4'b0000, 4'b0000, 8'd0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    drive(4'b0000, 4'b0000, 8'd0, 1'b0);
    checks++; if (b.credit_count !== 3'd4) begin fails++; $display("FAIL reset_credit got %0d exp 4", b.credit_count); end
    checks++; if (b.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", b.out_valid); end
    checks++; if (b.out_data !== 16'h0) begin fails++; $display("FAIL reset_out_data got %h exp 0000", b.out_data); end
    checks++; if (b.out_req_id !== 2'd0 || b.out_tail !== 1'b0) begin fails++; $display("FAIL reset_id_tail got %0d/%b exp 0/0", b.out_req_id, b.out_tail); end
    checks++; if (b.credit_err !== 1'b0) begin fails++; $display("FAIL reset_err got %b exp 0", b.credit_err); end
    checks++; if (b.grant_count !== 32'h0) begin fails++; $display("FAIL reset_gc got %h exp 0", b.grant_count); end
    checks++; if (b.req_ready !== 4'b0000) begin fails++; $display("FAIL reset_ready got %b exp 0000", b.req_ready); end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(4'b1111, 4'b1111, 8'(k), 1'b1);
      checks++; if (b.req_ready !== 4'(1 << (k % 4))) begin fails++; $display("FAIL rr_ready[%0d] got %b exp %b", k, b.req_ready, 4'(1 << (k % 4))); end
      tick();
      checks++; if (b.out_valid !== 1'b1 || b.out_req_id !== 2'(k % 4) || b.out_data !== fd(k % 4, 8'(k)))
        begin fails++; $display("FAIL rr_out[%0d] got v=%b id=%0d d=%h exp v=1 id=%0d d=%h", k, b.out_valid, b.out_req_id, b.out_data, k % 4, fd(k % 4, 8'(k))); end
    end
    drive(4'b0000, 4'b0000, 8'd0, 1'b0);
    tick();
    checks++; if (b.out_valid !== 1'b0 || b.credit_count !== 3'd4) begin fails++; $display("FAIL rr_idle got v=%b cr=%0d exp v=0 cr=4", b.out_valid, b.credit_count); end
  endtask

  task automatic test_lock();
    logic [3:0] exp_rdy [9] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
    logic [3:0] vv [9]      = '{4'b0011, 4'b0011, 4'b0011, 4'b0010, 4'b0011, 4'b0010, 4'b0010, 4'b0011, 4'b0010};
    logic [3:0] tt [9]      = '{4'b0010, 4'b0010, 4'b0011, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0011, 4'b0010};
    logic       ov [9]      = '{1, 1, 1, 1, 1, 0, 0, 1, 1};
    logic [1:0] oid [9]     = '{0, 0, 0, 1, 0, 0, 0, 0, 1};
    do_reset();
    for (int k = 0; k < 9; k++) begin
      drive(vv[k], tt[k], 8'(k), ov[k]);
      checks++; if (b.req_ready !== exp_rdy[k]) begin fails++; $display("FAIL lock_ready[%0d] got %b exp %b", k, b.req_ready, exp_rdy[k]); end
      tick();
      checks++; if (b.out_valid !== ov[k] || (ov[k] && (b.out_req_id !== oid[k] || b.out_data !== fd(oid[k], 8'(k)))))
        begin fails++; $display("FAIL lock_out[%0d] got v=%b id=%0d d=%h exp v=%b id=%0d d=%h", k, b.out_valid, b.out_req_id, b.out_data, ov[k], oid[k], fd(oid[k], 8'(k))); end
    end
    checks++; if (b.credit_count !== 3'd4 || b.credit_err !== 1'b0) begin fails++; $display("FAIL lock_credit got %0d/%b exp 4/0", b.credit_count, b.credit_err); end
  endtask

  task automatic test_credit_exhaustion();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(4'b0100, 4'b0000, 8'(k), 1'b0);
      checks++; if (b.req_ready !== 4'b0100) begin fails++; $display("FAIL exh_ready[%0d] got %b exp 0100", k, b.req_ready); end
      tick();
      checks++; if (b.out_valid !== 1'b1 || b.out_req_id !== 2'd2 || b.out_data !== fd(2, 8'(k)))
        begin fails++; $display("FAIL exh_out[%0d] got v=%b id=%0d d=%h exp v=1 id=2 d=%h", k, b.out_valid, b.out_req_id, b.out_data, fd(2, 8'(k))); end
    end
    checks++; if (b.credit_count !== 3'd0) begin fails++; $display("FAIL exh_zero got %0d exp 0", b.credit_count); end
    drive(4'b0100, 4'b0000, 8'd4, 1'b1);
    checks++; if (b.req_ready !== 4'b0000) begin fails++; $display("FAIL exh_stall got %b exp 0000", b.req_ready); end
    tick();
    checks++; if (b.out_valid !== 1'b0 || b.out_data !== fd(2, 8'd3) || b.credit_count !== 3'd1)
      begin fails++; $display("FAIL exh_hold got v=%b d=%h cr=%0d exp v=0 d=%h cr=1", b.out_valid, b.out_data, b.credit_count, fd(2, 8'd3)); end
    drive(4'b0100, 4'b0000, 8'd4, 1'b0);
    tick();
    checks++; if (b.out_valid !== 1'b1 || b.out_data !== fd(2, 8'd4) || b.credit_count !== 3'd0)
      begin fails++; $display("FAIL exh_one got v=%b d=%h cr=%0d exp v=1 d=%h cr=0", b.out_valid, b.out_data, b.credit_count, fd(2, 8'd4)); end
    drive(4'b0100, 4'b0000, 8'd5, 1'b0);
    checks++; if (b.req_ready !== 4'b0000) begin fails++; $display("FAIL exh_only_one got %b exp 0000", b.req_ready); end
    tick();
    checks++; if (b.out_valid !== 1'b0) begin fails++; $display("FAIL exh_no_more got %b exp 0", b.out_valid); end
  endtask

  task automatic test_simultaneous_credit();
    do_reset();
    drive(4'b0001, 4'b0001, 8'd0, 1'b0);
    tick();
    checks++; if (b.credit_count !== 3'd3) begin fails++; $display("FAIL sim_pre got %0d exp 3", b.credit_count); end
    drive(4'b0001, 4'b0001, 8'd1, 1'b1);
    tick();
    checks++; if (b.credit_count !== 3'd3 || b.out_valid !== 1'b1) begin fails++; $display("FAIL sim_both got cr=%0d v=%b exp cr=3 v=1", b.credit_count, b.out_valid); end
    drive(4'b0000, 4'b0000, 8'd0, 1'b1);
    tick();
    checks++; if (b.credit_count !== 3'd4 || b.credit_err !== 1'b0) begin fails++; $display("FAIL sim_full got cr=%0d err=%b exp 4/0", b.credit_count, b.credit_err); end
    drive(4'b0000, 4'b0000, 8'd0, 1'b1);
    tick();
    checks++; if (b.credit_count !== 3'd4 || b.credit_err !== 1'b1) begin fails++; $display("FAIL sim_over got cr=%0d err=%b exp 4/1", b.credit_count, b.credit_err); end
    drive(4'b0000, 4'b0000, 8'd0, 1'b0);
    tick();
    tick();
    checks++; if (b.credit_err !== 1'b1) begin fails++; $display("FAIL sim_sticky got %b exp 1", b.credit_err); end
    do_reset();
    checks++; if (b.credit_err !== 1'b0) begin fails++; $display("FAIL sim_clear got %b exp 0", b.credit_err); end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    drive(4'b0010, 4'b0000, 8'd0, 1'b0);
    tick();
    rst = 1'b1;
    drive(4'b0010, 4'b0000, 8'd1, 1'b0);
    tick();
    rst = 1'b0;
    checks++; if (b.out_valid !== 1'b0 || b.credit_count !== 3'd4) begin fails++; $display("FAIL rmp_state got v=%b cr=%0d exp v=0 cr=4", b.out_valid, b.credit_count); end
    drive(4'b1000, 4'b1000, 8'd2, 1'b0);
    checks++; if (b.req_ready !== 4'b1000) begin fails++; $display("FAIL rmp_ready got %b exp 1000", b.req_ready); end
    tick();
    checks++; if (b.out_valid !== 1'b1 || b.out_req_id !== 2'd3) begin fails++; $display("FAIL rmp_grant got v=%b id=%0d exp v=1 id=3", b.out_valid, b.out_req_id); end
  endtask

  task automatic test_stats();
    logic [7:0] e;
    do_reset();
    drive(4'b0010, 4'b0000, 8'd0, 1'b1);
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(4'b0010, 4'b0010, 8'(k), 1'b1);
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      drive(4'b1000, 4'b1000, 8'(k), 1'b1);
      tick();
    end
    drive(4'b0000, 4'b0000, 8'd0, 1'b0);
    tick();
    for (int r = 0; r < 4; r++) begin
`ifdef NOC_ARB_STATS_EN
      e = r == 1 ? 8'd5 : r == 3 ? 8'd2 : 8'd0;
`else
      e = 8'd0;
`endif
      checks++; if (b.grant_count[r*8 +: 8] !== e) begin fails++; $display("FAIL stats_gc[%0d] got %0d exp %0d", r, b.grant_count[r*8 +: 8], e); end
    end
  endtask

  initial begin
    b.req_valid = '0;
    b.req_tail = '0;
    b.req_data = '0;
    b.credit_in = 1'b0;
    test_reset();
    test_round_robin();
    test_lock();
    test_credit_exhaustion();
    test_simultaneous_credit();
    test_reset_mid_packet();
    test_stats();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/noc_port_arbiter.md
# noc_port_arbiter

Shares one NoC router input port among `NUM_REQ` local traffic sources in the multi-clock NoC emulation. It performs round-robin arbitration with wormhole packet locking, so a granted packet holds the port until its tail flit. It enforces credit-based flow control toward the router and registers the winning flit onto the router-facing input bus. One instance sits in front of each router node, in that node's clock domain.

## Interface
- `WIDTH`, 600: flit width in bits, equal to the NoC width.
- `NUM_REQ`, 4: number of requesters, 2..16.
- `CREDITS`, 8: downstream buffer depth; the credit counter resets to this value.
- `CNT_W`, 16: width of the per-requester grant counters (used only with `NOC_ARB_STATS_EN`).

Ports (`ID_W` = $clog2(`NUM_REQ`); `CR_W` = $clog2(`CREDITS`+1)):
- `clk`  in  1  node clock.
- `rst`  in  1  synchronous reset, active-high.
- `req_valid`  in  NUM_REQ  per-requester flit valid.
- `req_data`  in  NUM_REQ*WIDTH  flattened flits; requester r occupies bits [r*WIDTH +: WIDTH].
- `req_tail`  in  NUM_REQ  the flit is the last of its packet.
- `req_ready`  out  NUM_REQ  one-hot-or-zero accept.
- `out_valid`  out  1  registered flit valid toward the router.
- `out_data`  out  WIDTH  registered flit.
- `out_tail`  out  1  registered tail marker.
- `out_req_id`  out  ID_W  source requester of `out_data`.
- `credit_in`  in  1  one-cycle pulse: the router freed one buffer slot.
- `credit_count`  out  CR_W  current credits.
- `credit_err`  out  1  sticky flag: a credit returned while the counter was already at `CREDITS`.
- `grant_count`  out  NUM_REQ*CNT_W  accepted-packet counters (only with `NOC_ARB_STATS_EN`).

## Operation
- A flit is accepted on a cycle where `req_valid[r] & req_ready[r]`.
- States: IDLE and LOCKED(owner).
- **IDLE:**
  - If `credit_count > 0` and any `req_valid` is high, pick the winner by round-robin, searching from `rr_ptr` upward with wrap-around.
  - `req_ready` is asserted for the winner only, and the flit is accepted that same cycle.
  - Accepted flit is a tail (single-flit packet): stay in IDLE; `rr_ptr` = winner+1 mod `NUM_REQ`.
  - Accepted flit is not a tail: go to LOCKED(winner).
- **LOCKED(o):**
  - `req_ready[o] = credit_count > 0`; all other readies are 0, regardless of their valids.
  - An accepted tail returns the block to IDLE; `rr_ptr` = o+1 mod `NUM_REQ`.
  - A bubble (`req_valid[o]` = 0) holds the lock indefinitely.
- **Credits:**
  - The counter decrements on an accept and increments on `credit_in`.
  - Both in the same cycle: the counter is unchanged.
  - At 0: no `req_ready` is asserted.
  - `credit_in` with the counter at `CREDITS` (and no accept that cycle): the counter saturates and `credit_err` is set until reset.
- **Output register:**
  - On an accept, `out_valid` is 1 and `out_data`, `out_tail`, `out_req_id` load the accepted flit.
  - Otherwise `out_valid` is 0 and the data fields hold their last values.
- **Reset values:**
  - State IDLE, `rr_ptr` = 0, `credit_count` = `CREDITS`.
  - `out_valid`, `out_tail`, `out_req_id`, `credit_err` = 0; `out_data` = 0; `grant_count` all 0.
- **Reset mid-packet:** the lock is dropped and the partial packet is abandoned; the requester must resend.
- `req_valid` must not depend on `req_ready` (no combinational loop).

## Timing
- `req_ready` is combinational from state, `rr_ptr`, `credit_count` and `req_valid`.
- Latency is 1 cycle: a flit accepted in cycle t appears on `out_*` in cycle t+1.
- Throughput is 1 flit/cycle while credits last; no dead cycle between packets from different requesters.
- `credit_count` updates at the clock edge after the accept or `credit_in`.
- Winner selection and its priority encode must close timing at `NUM_REQ` = 16.

## Configuration
- `NOC_ARB_STATS_EN` defined:
  - `grant_count[r]` increments by 1 on each accepted tail flit from requester r (one count per packet).
  - The counter wraps at 2^`CNT_W`.
- Macro undefined:
  - The `grant_count` port still exists and is tied to 0.
  - No counter logic is synthesized.

## Test plan
- **Round-robin:** `NUM_REQ`=4, all four valid with single-flit packets, ample credits -> `out_req_id` sequence 0,1,2,3,0 on consecutive cycles; `out_valid` continuous from cycle 1.
- **Packet locking:** req0 sends a 3-flit packet while req1 is continuously valid -> the 3 req0 flits appear back-to-back; req1 is first output on the cycle after req0's tail; a req0 bubble mid-packet still blocks req1.
- **Credit exhaustion:** `CREDITS`=2, no `credit_in`, req2 sends a 4-flit packet -> 2 flits output, then `req_ready`=0 and `credit_count`=0; one `credit_in` pulse -> exactly one more flit.
- **Simultaneous accept and credit:** accept and `credit_in` in the same cycle with `credit_count`=3 -> the count stays 3. An extra `credit_in` at full -> the count stays `CREDITS` and `credit_err`=1 until `rst`.
- **Reset mid-packet:** assert `rst` during the second flit of a req1 packet -> the next cycle shows IDLE, `out_valid`=0, `credit_count`=`CREDITS`, and a new req3 request is granted immediately.
- **`NOC_ARB_STATS_EN`:** 5 packets from req1 and 2 from req3 -> `grant_count[1]`=5, `grant_count[3]`=2, others 0. Without the macro, all counts are 0.
